// File: rtl/ped_pkg.sv
// ped_pkg: shared state enumeration and default timing constants for the pedestrian signal
package ped_pkg;
  typedef enum logic [1:0] {ST_STOP, ST_WALK, ST_FLASH, ST_FAULT} ped_state_e;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_WALK_TIME    = 10;
  localparam int DEF_FLASH_TIME   = 8;
  localparam int DEF_FLASH_HALF   = 1;
endpackage

// File: rtl/ped_debounce.sv
// ped_debounce: two-flop synchroniser plus stable-count debouncer for the raw button
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  logic s1_q, s1_d, s2_q, s2_d, level_q, level_d;
  logic [5:0] cnt_q, cnt_d;
  // accept the synchronised value only after it differs for DEBOUNCE_CYC cycles in a row
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    level_d = level_q;
    cnt_d = '0;
    if (s2_q != level_q) begin
      if (cnt_q == 6'(DEBOUNCE_CYC - 1)) level_d = s2_q;
      else cnt_d = cnt_q + 6'd1;
    end
  end
  // synchroniser and debounce state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK/FLASH controller slaved to vehicle lamps (optional PED_COUNTDOWN_EN countdown output)
module ped_signal_ctrl
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int WALK_TIME    = DEF_WALK_TIME,
  parameter int FLASH_TIME   = DEF_FLASH_TIME,
  parameter int FLASH_HALF   = DEF_FLASH_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red_in,
  input  logic yellow_in,
  input  logic green_in,
  input  logic ped_btn,
  output logic walk,
  output logic dont_walk,
  output logic ped_wait,
  output logic abort,
  output logic fault
`ifdef PED_COUNTDOWN_EN
  , output logic [5:0] countdown
`endif
);
  localparam logic [5:0] WT = 6'(WALK_TIME);
  localparam logic [5:0] FT = 6'(FLASH_TIME);
  localparam logic [5:0] FH = 6'(FLASH_HALF);
  ped_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d, half_idx;
  logic deb_level, deb_prev_q, red_prev_q;
  logic walk_q, walk_d, dont_walk_q, dont_walk_d, ped_wait_q, ped_wait_d;
  logic abort_q, abort_d, fault_q, fault_d;
  logic red_only, red_entry, illegal, rise;
  ped_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk(clk), .rst_n(rst_n), .raw(ped_btn), .level(deb_level)
  );
  assign red_only  = red_in & ~yellow_in & ~green_in;
  assign red_entry = red_only & ~red_prev_q;
  assign illegal   = green_in & (red_in | yellow_in);
  assign rise      = deb_level & ~deb_prev_q;
  // next state, phase counter, request latch and registered lamp values
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    ped_wait_d = ped_wait_q | rise;
    abort_d = 1'b0;
    if (state_q == ST_FAULT || illegal) state_d = ST_FAULT;
    else if (state_q == ST_STOP) begin
      if (red_entry && ped_wait_d) begin
        state_d = ST_WALK;
        ped_wait_d = 1'b0;
      end
    end else if (!red_only) begin
      state_d = ST_STOP;
      abort_d = 1'b1;
    end else if (state_q == ST_WALK && cnt_q == WT - 6'd1) state_d = ST_FLASH;
    else if (state_q == ST_FLASH && cnt_q == FT - 6'd1) state_d = ST_STOP;
    else cnt_d = cnt_q + 6'd1;
    half_idx = cnt_d / FH;
    walk_d = state_d == ST_WALK;
    dont_walk_d = state_d == ST_FLASH ? ~half_idx[0] : state_d != ST_WALK;
    fault_d = state_d == ST_FAULT;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      cnt_q <= '0;
      deb_prev_q <= 1'b0;
      red_prev_q <= 1'b1;
      walk_q <= 1'b0;
      dont_walk_q <= 1'b1;
      ped_wait_q <= 1'b0;
      abort_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      deb_prev_q <= deb_level;
      red_prev_q <= red_only;
      walk_q <= walk_d;
      dont_walk_q <= dont_walk_d;
      ped_wait_q <= ped_wait_d;
      abort_q <= abort_d;
      fault_q <= fault_d;
    end
  end
  assign walk = walk_q;
  assign dont_walk = dont_walk_q;
  assign ped_wait = ped_wait_q;
  assign abort = abort_q;
  assign fault = fault_q;
`ifdef PED_COUNTDOWN_EN
  logic [5:0] countdown_q, countdown_d;
  // remaining cycles of the phase being entered or continued
  always_comb countdown_d = state_d == ST_WALK ? WT - cnt_d : state_d == ST_FLASH ? FT - cnt_d : 6'd0;
  // countdown register
  always_ff @(posedge clk) countdown_q <= !rst_n ? 6'd0 : countdown_d;
  assign countdown = countdown_q;
`endif
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb_ped_signal_ctrl: randomized scoreboard bench with a behavioural pedestrian-signal model
module tb_ped_signal_ctrl;
  localparam int N = 4, WT = 10, FT = 8, FH = 1;
  localparam logic [2:0] L_G = 3'b001, L_Y = 3'b010, L_R = 3'b100, L_RY = 3'b110, L_RG = 3'b101, L_YG = 3'b011;
  logic clk = 0, rst_n = 0, red_in = 0, yellow_in = 0, green_in = 0, ped_btn = 0;
  logic walk, dont_walk, ped_wait, abort, fault;
`ifdef PED_COUNTDOWN_EN
  logic [5:0] countdown;
`endif
  ped_signal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .red_in(red_in), .yellow_in(yellow_in), .green_in(green_in),
    .ped_btn(ped_btn), .walk(walk), .dont_walk(dont_walk), .ped_wait(ped_wait),
    .abort(abort), .fault(fault)
`ifdef PED_COUNTDOWN_EN
    , .countdown(countdown)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {logic w, dw, pw, ab, ft; int cd;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;

  // reference model: phases 0 STOP, 1 WALK, 2 FLASH, 3 FAULT; age = edges since phase entry
  int ph = 0, age = 0;
  bit pw = 0, prev_ro = 1, deb = 0, deb_prev = 0;
  bit rawh[$], synh[$];
  always @(posedge clk) begin : model
    exp_t e;
    bit ro, ent, ill, rise, sy, flip, ab;
    cyc++;
    ab = 0;
    if (!rst_n) begin
      ph = 0; age = 0; pw = 0; prev_ro = 1; deb = 0; deb_prev = 0;
      rawh.delete(); synh.delete();
    end else begin
      ro = red_in && !yellow_in && !green_in;
      ent = ro && !prev_ro;
      ill = green_in && (red_in || yellow_in);
      rise = deb && !deb_prev;
      pw = pw || rise;
      if (ph == 3 || ill) ph = 3;
      else if (ph == 0) begin
        if (ent && pw) begin ph = 1; age = 0; pw = 0; end
      end else if (!ro) begin ph = 0; ab = 1; end
      else begin
        age++;
        if (ph == 1 && age == WT) begin ph = 2; age = 0; end
        else if (ph == 2 && age == FT) ph = 0;
      end
      prev_ro = ro;
      sy = rawh.size() >= 2 ? rawh[rawh.size()-2] : 1'b0;
      rawh.push_back(ped_btn);
      if (rawh.size() > 2) void'(rawh.pop_front());
      synh.push_back(sy);
      if (synh.size() > N) void'(synh.pop_front());
      flip = synh.size() == N;
      foreach (synh[i]) if (synh[i] == deb) flip = 0;
      deb_prev = deb;
      if (flip) deb = !deb;
    end
    e.w = ph == 1;
    e.dw = ph == 2 ? ((age / FH) % 2 == 0) : ph != 1;
    e.pw = pw;
    e.ab = ab;
    e.ft = ph == 3;
    e.cd = ph == 1 ? WT - age : ph == 2 ? FT - age : 0;
    exp_q.push_back(e);
  end

  task automatic chk(string n, logic [7:0] a, logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", n, cyc, a, x);
    end
  endtask

  // monitor: compare every registered output against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("walk", 8'(walk), 8'(e.w));
      chk("dont_walk", 8'(dont_walk), 8'(e.dw));
      chk("ped_wait", 8'(ped_wait), 8'(e.pw));
      chk("abort", 8'(abort), 8'(e.ab));
      chk("fault", 8'(fault), 8'(e.ft));
`ifdef PED_COUNTDOWN_EN
      chk("countdown", 8'(countdown), 8'(e.cd));
`endif
    end
  end

  task automatic drv(logic [2:0] l, bit b, int n, bit rn = 1);
    repeat (n) begin
      @(negedge clk);
      {red_in, yellow_in, green_in} = l;
      ped_btn = b;
      rst_n = rn;
    end
  endtask

  initial begin
    logic [2:0] l;
    bit b;
    int r, n;
    drv(L_G, 0, 3, 0);
    drv(L_G, 1, 10); drv(L_G, 0, 5); drv(L_Y, 0, 2); drv(L_R, 0, 25);
    drv(L_G, 0, 3); drv(L_G, 1, 3); drv(L_G, 0, 10); drv(L_R, 0, 5);
    drv(L_G, 1, 8); drv(L_Y, 0, 2); drv(L_R, 0, 4); drv(L_RY, 0, 3); drv(L_R, 0, 3);
    drv(L_G, 1, 8); drv(L_R, 0, 6); drv(L_R, 1, 8); drv(L_R, 0, 12); drv(L_G, 0, 3); drv(L_R, 0, 25);
    drv(L_R, 1, 4); drv(L_G, 0, 4); drv(L_R, 0, 5); drv(L_R, 0, 2, 0);
    drv(L_R, 0, 3); drv(L_RG, 0, 1); drv(L_R, 0, 5); drv(L_G, 1, 3); drv(L_G, 0, 2, 0);
    b = 0;
    repeat (150) begin
      r = $urandom_range(0, 99);
      l = r < 2 ? L_RG : r < 4 ? L_YG : r < 30 ? L_G : r < 40 ? L_Y : r < 50 ? L_RY : L_R;
      n = $urandom_range(1, 30);
      repeat (n) begin
        if ($urandom_range(0, 7) == 0) b = !b;
        drv(l, b, 1);
      end
      if (r < 4 || $urandom_range(0, 39) == 0) drv(L_R, b, 2, 0);
    end
    drv(L_R, 0, 3);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 8'(exp_q.size() > 1), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
